mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one single-port memory.
// The data port normally wins; the fetch port is forced through after STARVE_LIMIT losses.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pipe_stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [2:0]  starve_cnt, starve_cnt_nxt;
  logic        mem_en_nxt, mem_we_nxt, if_ready_nxt, dm_ready_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 3'd1;
  endfunction

  assign pipe_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    mem_en_nxt     = mem_en;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    if_ready_nxt   = 1'b0;
    dm_ready_nxt   = 1'b0;
    if_rdata_nxt   = if_rdata;
    dm_rdata_nxt   = dm_rdata;
    case (state)
      IDLE: begin
        // Data wins unless the fetch port has already lost STARVE_LIMIT times in a row.
        if (dm_req && !(if_req && starve_cnt == LIMIT)) begin
          state_nxt     = BUSY_D;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr;
          mem_wdata_nxt = dm_wdata;
          if (if_req) starve_cnt_nxt = sat_inc(starve_cnt);
        end else if (if_req) begin
          state_nxt      = BUSY_I;
          mem_en_nxt     = 1'b1;
          mem_we_nxt     = 1'b0;
          mem_addr_nxt   = if_addr;
          starve_cnt_nxt = 3'd0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_nxt    = DONE;
          mem_en_nxt   = 1'b0;
          mem_we_nxt   = 1'b0;
          if_ready_nxt = 1'b1;
          if_rdata_nxt = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_nxt    = DONE;
          mem_en_nxt   = 1'b0;
          mem_we_nxt   = 1'b0;
          dm_ready_nxt = 1'b1;
          if (!mem_we) dm_rdata_nxt = mem_rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= 32'd0;
      dm_rdata   <= 32'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_ready   <= if_ready_nxt;
      dm_ready   <= dm_ready_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_rdata   <= dm_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load/store, contention order, stall, reset abort, idle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we, pipe_stall;

  int n_asrt = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    string      order;
    logic [7:0] g;
    int         n_grant;

    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_dm_ready", 32'(dm_ready), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b1;

    // Single fetch, ack on first BUSY cycle
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1 chk("f_stall_req", 32'(pipe_stall), 32'd1);
    tick();
    chk("f_c1_en", 32'(mem_en), 32'd1);
    chk("f_c1_we", 32'(mem_we), 32'd0);
    chk("f_c1_addr", mem_addr, 32'h40);
    chk("f_c1_ready", 32'(if_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    tick();
    chk("f_c2_ready", 32'(if_ready), 32'd1);
    chk("f_c2_rdata", if_rdata, 32'h2008_0005);
    chk("f_c2_en", 32'(mem_en), 32'd0);
    chk("f_c2_stall", 32'(pipe_stall), 32'd0);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("f_c3_state", 32'(dut.state), 32'd0);
    chk("f_c3_ready", 32'(if_ready), 32'd0);
    chk("f_c3_rdata_hold", if_rdata, 32'h2008_0005);

    // Load so dm_rdata holds a known non-zero value
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    tick();
    chk("ld_en", 32'(mem_en), 32'd1);
    chk("ld_we", 32'(mem_we), 32'd0);
    chk("ld_addr", mem_addr, 32'h20);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("ld_ready", 32'(dm_ready), 32'd1);
    chk("ld_rdata", dm_rdata, 32'h1234_5678);
    dm_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Store with ack delayed 3 cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_en%0d", i), 32'(mem_en), 32'd1);
      chk($sformatf("st_we%0d", i), 32'(mem_we), 32'd1);
      chk($sformatf("st_addr%0d", i), mem_addr, 32'h10);
      chk($sformatf("st_wdata%0d", i), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st_ready%0d", i), 32'(dm_ready), 32'd0);
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    chk("st_ready", 32'(dm_ready), 32'd1);
    chk("st_rdata_kept", dm_rdata, 32'h1234_5678);
    chk("st_done_en", 32'(mem_en), 32'd0);
    chk("st_done_we", 32'(mem_we), 32'd0);
    dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    tick();
    chk("st_ready_pulse", 32'(dm_ready), 32'd0);

    // Contention with zero-wait memory
    order = "DDDIDDDI";
    if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    mem_ack = 1'b1; mem_rdata = 32'h0C0F_FEE0;
    n_grant = 0;
    for (int cyc = 0; cyc < 40 && n_grant < 8; cyc++) begin
      tick();
      if (mem_en) begin
        g = (mem_addr == 32'h100) ? 8'h49 : 8'h44;
        chk($sformatf("grant%0d", n_grant), 32'(g), 32'(order[n_grant]));
        if (n_grant == 2) chk("starve_sat", 32'(dut.starve_cnt), 32'd3);
        if (n_grant == 3) chk("starve_clr", 32'(dut.starve_cnt), 32'd0);
        n_grant++;
      end
    end
    chk("grant_count", 32'(n_grant), 32'd8);
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick();
    mem_ack = 1'b0;
    chk("cont_idle", 32'(dut.state), 32'd0);

    // Stall while a load waits behind a fetch
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    #1 chk("ps_0", 32'(pipe_stall), 32'd1);
    tick();
    chk("ps_1", 32'(pipe_stall), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    chk("ps_if_ready", 32'(if_ready), 32'd1);
    chk("ps_if_rdata", if_rdata, 32'hAAAA_0001);
    chk("ps_2", 32'(pipe_stall), 32'd1);
    if_req = 1'b0; mem_ack = 1'b0;
    #1 chk("ps_3", 32'(pipe_stall), 32'd1);
    tick();
    chk("ps_4", 32'(pipe_stall), 32'd1);
    tick();
    chk("ps_5", 32'(pipe_stall), 32'd1);
    chk("ps_d_addr", mem_addr, 32'h400);
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_0002;
    tick();
    chk("ps_dm_ready", 32'(dm_ready), 32'd1);
    chk("ps_dm_rdata", dm_rdata, 32'hBBBB_0002);
    chk("ps_6", 32'(pipe_stall), 32'd0);
    dm_req = 1'b0; mem_ack = 1'b0;
    #1 chk("ps_7", 32'(pipe_stall), 32'd0);
    tick();

    // Reset during BUSY_D, late ack ignored
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h55;
    tick();
    chk("ra_en", 32'(mem_en), 32'd1);
    rst = 1'b0;
    tick();
    chk("ra_en0", 32'(mem_en), 32'd0);
    chk("ra_we0", 32'(mem_we), 32'd0);
    chk("ra_addr0", mem_addr, 32'd0);
    chk("ra_wdata0", mem_wdata, 32'd0);
    chk("ra_if_rdata0", if_rdata, 32'd0);
    chk("ra_dm_rdata0", dm_rdata, 32'd0);
    chk("ra_state", 32'(dut.state), 32'd0);
    rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b1;
    tick();
    chk("ra_no_ready", 32'(dm_ready), 32'd0);
    chk("ra_en_late", 32'(mem_en), 32'd0);
    chk("ra_state_late", 32'(dut.state), 32'd0);
    mem_ack = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle_en%0d", i), 32'(mem_en), 32'd0);
      chk($sformatf("idle_stall%0d", i), 32'(pipe_stall), 32'd0);
    end
    chk("idle_starve", 32'(dut.starve_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
